// File: rtl/flit_sink_pkg.sv
// flit_sink_pkg
//   Shared sizes, the flit layout, FSM state encoding, checker error codes
//   and small helpers for the flit_sink ejection consumer.
//   Flit layout, MSB first: {full, vc, head, tail, dst, payload}.
package flit_sink_pkg;

  localparam int MAXVC  = 4;
  localparam int VC_W   = 2;
  localparam int RID_W  = 4;
  localparam int PAY_W  = 8;
  localparam int MAX_CD = 8;
  localparam int CD_W   = $clog2(MAX_CD + 1);
  localparam int TAP_W  = $clog2(MAX_CD);
  localparam int CNT_W  = 16;
  localparam int FLIT_W = 1 + VC_W + 1 + 1 + RID_W + PAY_W;

  typedef struct packed {
    logic             full;
    logic [VC_W-1:0]  vc;
    logic             head;
    logic             tail;
    logic [RID_W-1:0] dst;
    logic [PAY_W-1:0] payload;
  } flit_t;

  typedef enum logic [1:0] {
    ST_UNCFG = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [2:0] ERR_NONE            = 3'd0;
  localparam logic [2:0] ERR_BAD_DST         = 3'd1;
  localparam logic [2:0] ERR_HEAD_WHILE_BUSY = 3'd2;
  localparam logic [2:0] ERR_BODY_WHILE_IDLE = 3'd3;
  localparam logic [2:0] ERR_BAD_VC          = 3'd4;
  localparam logic [2:0] ERR_AFTER_DONE      = 3'd5;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // A delay of 0 would mean "same cycle", which the pipeline cannot do;
  // treat it as 1 and cap at the delay-line depth.
  function automatic logic [CD_W-1:0] clamp_cd(input logic [CD_W-1:0] d);
    if (d == '0) return CD_W'(1);
    if (d > CD_W'(MAX_CD)) return CD_W'(MAX_CD);
    return d;
  endfunction

endpackage

// File: rtl/flit_sink_if.sv
// flit_sink_if
//   Router local-out port as seen by the ejection sink.
//   flit          router -> sink   raw flit word (see flit_sink_pkg::flit_t)
//   credit_valid  sink -> router   one buffer slot returned this cycle
//   credit_vc     sink -> router   vc of the returned slot
//   master = router side, slave = sink side.
interface flit_sink_if;
  import flit_sink_pkg::*;

  logic [FLIT_W-1:0] flit;
  logic              credit_valid;
  logic [VC_W-1:0]   credit_vc;

  modport master (output flit, input credit_valid, input credit_vc);
  modport slave  (input flit, output credit_valid, output credit_vc);
endinterface

// File: rtl/flit_sink_credit_delay_line.sv
// credit_delay_line
//   MAX_CD-deep shift register of {valid, vc}. Stage k holds an entry
//   pushed k+1 edges ago; the output tap is stage delay-1, so an entry
//   pushed at edge T appears in the cycle following edge T+delay-1.
//   clk, rst     clock, async active-high reset
//   flush        clears every stage (entry on in_* that cycle is lost)
//   in_valid/vc  credit to queue
//   delay        1..MAX_CD, already clamped by the caller
//   out_valid/vc credit leaving the line this cycle
module credit_delay_line
  import flit_sink_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [VC_W-1:0] in_vc,
  input  logic [CD_W-1:0] delay,
  output logic            out_valid,
  output logic [VC_W-1:0] out_vc
);

  logic [MAX_CD-1:0] v_q;
  logic [VC_W-1:0]   vc_q [MAX_CD];
  logic [TAP_W-1:0]  tap;

  assign tap = TAP_W'(delay - CD_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < MAX_CD; i++) vc_q[i] <= '0;
    end else if (flush) begin
      v_q <= '0;
      for (int i = 0; i < MAX_CD; i++) vc_q[i] <= '0;
    end else begin
      v_q     <= {v_q[MAX_CD-2:0], in_valid};
      vc_q[0] <= in_vc;
      for (int i = 1; i < MAX_CD; i++) vc_q[i] <= vc_q[i-1];
    end
  end

  assign out_valid = v_q[tap];
  assign out_vc    = vc_q[tap];

endmodule

// File: rtl/flit_sink.sv
// flit_sink
//   Ejection-side consumer for one router. Counts delivered flits and
//   packets per configuration run, tracks head..tail per VC and returns a
//   credit for every accepted flit after the configured delay.
//   Optional protocol checker built when SINK_CHECK_EN is defined;
//   otherwise err/err_code are tied low.
// Ports
//   clk, rst            clock, async active-high reset
//   init                1-cycle strobe: latch cfg_* and clear run state
//   cfg_router_id       this node's id
//   cfg_num_vcs         active VCs, 1..MAXVC
//   cfg_credit_delay    credit return delay (0 -> 1, >MAX_CD -> MAX_CD)
//   cfg_expected        packets this node must receive
//   snk                 flit in / credit out (flit_sink_if.slave)
//   flit_count          flits accepted (saturating)
//   pkt_count           tails accepted (saturating)
//   vc_busy             bit v: head seen on v, tail not yet
//   done                pkt_count >= cfg_expected while configured
//   err, err_code       sticky first protocol error and its code
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_UNCFG | after reset, flits ignored until init
// ST_RUN   | accepting flits, expected count not yet reached
// ST_DONE  | expected count reached, still accepting/draining
module flit_sink
  import flit_sink_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic [RID_W-1:0]  cfg_router_id,
  input  logic [VC_W:0]     cfg_num_vcs,
  input  logic [CD_W-1:0]   cfg_credit_delay,
  input  logic [CNT_W-1:0]  cfg_expected,
  flit_sink_if.slave        snk,
  output logic [CNT_W-1:0]  flit_count,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [MAXVC-1:0]  vc_busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        err_code
);

  state_e            state;
  logic [RID_W-1:0]  rid_r;
  logic [VC_W:0]     nvc_r;
  logic [CD_W-1:0]   cd_r;
  logic [CNT_W-1:0]  exp_r;

  flit_t             f;
  logic              take;
  logic              vc_ok;
  logic              accept;
  logic [CNT_W-1:0]  flit_nxt;
  logic [CNT_W-1:0]  pkt_nxt;
  logic [MAXVC-1:0]  busy_nxt;

  assign f = flit_t'(snk.flit);

  always_comb begin
    // A flit arriving together with init belongs to the old run: discard it.
    take     = f.full && (state != ST_UNCFG) && !init;
    vc_ok    = ({1'b0, f.vc} < nvc_r);
    accept   = take && vc_ok;
    flit_nxt = accept ? sat_inc(flit_count) : flit_count;
    pkt_nxt  = (accept && f.tail) ? sat_inc(pkt_count) : pkt_count;
    busy_nxt = vc_busy;
    if (accept) begin
      // Tail wins over head so a one-flit packet leaves the vc idle.
      if (f.tail)      busy_nxt[f.vc] = 1'b0;
      else if (f.head) busy_nxt[f.vc] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_UNCFG;
      rid_r      <= '0;
      nvc_r      <= '0;
      cd_r       <= '0;
      exp_r      <= '0;
      flit_count <= '0;
      pkt_count  <= '0;
      vc_busy    <= '0;
      done       <= 1'b0;
    end else if (init) begin
      state      <= ST_RUN;
      rid_r      <= cfg_router_id;
      nvc_r      <= cfg_num_vcs;
      cd_r       <= clamp_cd(cfg_credit_delay);
      exp_r      <= cfg_expected;
      flit_count <= '0;
      pkt_count  <= '0;
      vc_busy    <= '0;
      done       <= (cfg_expected == '0);
    end else begin
      case (state)
        ST_UNCFG: begin
        end
        ST_RUN, ST_DONE: begin
          flit_count <= flit_nxt;
          pkt_count  <= pkt_nxt;
          vc_busy    <= busy_nxt;
          if (pkt_nxt >= exp_r) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_UNCFG;
      endcase
    end
  end

  credit_delay_line u_cdl (
    .clk       (clk),
    .rst       (rst),
    .flush     (init),
    .in_valid  (accept),
    .in_vc     (f.vc),
    .delay     (cd_r),
    .out_valid (snk.credit_valid),
    .out_vc    (snk.credit_vc)
  );

`ifdef SINK_CHECK_EN
  logic [2:0] chk_code;
  logic       unused_flit;

  assign unused_flit = ^f.payload;

  // Dropped flits can only report BAD_VC; accepted flits report the
  // lowest-numbered violation that applies.
  always_comb begin
    chk_code = ERR_NONE;
    if (take) begin
      if (!vc_ok)                          chk_code = ERR_BAD_VC;
      else if (f.dst != rid_r)             chk_code = ERR_BAD_DST;
      else if (f.head && vc_busy[f.vc])    chk_code = ERR_HEAD_WHILE_BUSY;
      else if (!f.head && !vc_busy[f.vc])  chk_code = ERR_BODY_WHILE_IDLE;
      else if (state == ST_DONE)           chk_code = ERR_AFTER_DONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else if (init) begin
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else if (!err && (chk_code != ERR_NONE)) begin
      err      <= 1'b1;
      err_code <= chk_code;
    end
  end
`else
  logic unused_flit;

  assign unused_flit = ^{f.payload, f.dst, rid_r};
  assign err         = 1'b0;
  assign err_code    = ERR_NONE;
`endif

endmodule

// File: tb/tb_flit_sink.sv
module tb_flit_sink;
  import flit_sink_pkg::*;

`ifdef SINK_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              init;
  logic [RID_W-1:0]  cfg_router_id;
  logic [VC_W:0]     cfg_num_vcs;
  logic [CD_W-1:0]   cfg_credit_delay;
  logic [CNT_W-1:0]  cfg_expected;
  logic [CNT_W-1:0]  flit_count;
  logic [CNT_W-1:0]  pkt_count;
  logic [MAXVC-1:0]  vc_busy;
  logic              done;
  logic              err;
  logic [2:0]        err_code;

  flit_sink_if bus ();

  flit_sink dut (
    .clk              (clk),
    .rst              (rst),
    .init             (init),
    .cfg_router_id    (cfg_router_id),
    .cfg_num_vcs      (cfg_num_vcs),
    .cfg_credit_delay (cfg_credit_delay),
    .cfg_expected     (cfg_expected),
    .snk              (bus),
    .flit_count       (flit_count),
    .pkt_count        (pkt_count),
    .vc_busy          (vc_busy),
    .done             (done),
    .err              (err),
    .err_code         (err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FLIT_W-1:0] mk(input logic [VC_W-1:0] vc, input logic head,
                                           input logic tail, input logic [RID_W-1:0] dst);
    flit_t t;
    t.full    = 1'b1;
    t.vc      = vc;
    t.head    = head;
    t.tail    = tail;
    t.dst     = dst;
    t.payload = 8'hA5;
    return t;
  endfunction

  task automatic do_init(input logic [RID_W-1:0] id, input logic [VC_W:0] nvc,
                         input logic [CD_W-1:0] cd, input logic [CNT_W-1:0] expv);
    cfg_router_id    = id;
    cfg_num_vcs      = nvc;
    cfg_credit_delay = cd;
    cfg_expected     = expv;
    init = 1'b1;
    step();
    init = 1'b0;
  endtask

  logic [FLIT_W-1:0] pkt3 [5];
  int e_busy [8] = '{1, 1, 1, 0, 0, 0, 0, 0};
  int e_fc   [8] = '{1, 2, 3, 4, 5, 5, 5, 5};
  int e_pc   [8] = '{0, 0, 0, 1, 2, 2, 2, 2};
  int e_done [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  int e_cv   [8] = '{0, 0, 1, 1, 1, 1, 1, 0};
  int e_cvc  [8] = '{0, 0, 0, 0, 0, 0, 1, 0};

  initial begin
    rst = 1'b1;
    init = 1'b0;
    cfg_router_id = '0;
    cfg_num_vcs = '0;
    cfg_credit_delay = '0;
    cfg_expected = '0;
    bus.flit = '0;
    step();
    step();

    // reset state
    chk("rst_flit_count", flit_count, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_vc_busy", vc_busy, 0);
    chk("rst_done", done, 0);
    chk("rst_credit_valid", bus.credit_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);
    rst = 1'b0;

    // unconfigured: flits ignored
    bus.flit = mk(2'd0, 1'b1, 1'b1, 4'd3);
    step();
    bus.flit = '0;
    chk("uncfg_flit_count", flit_count, 0);
    chk("uncfg_credit0", bus.credit_valid, 0);
    step();
    chk("uncfg_credit1", bus.credit_valid, 0);
    chk("uncfg_done", done, 0);

    // single one-flit packet, credit delay 3
    do_init(4'd3, 3'd2, 4'd3, 16'd2);
    chk("t2_done_after_init", done, 0);
    chk("t2_fc_after_init", flit_count, 0);
    bus.flit = mk(2'd1, 1'b1, 1'b1, 4'd3);
    step();
    bus.flit = '0;
    chk("t2_flit_count", flit_count, 1);
    chk("t2_pkt_count", pkt_count, 1);
    chk("t2_busy", vc_busy, 0);
    chk("t2_credit_t0", bus.credit_valid, 0);
    step();
    chk("t2_credit_t1", bus.credit_valid, 0);
    step();
    chk("t2_credit_t2", bus.credit_valid, 1);
    chk("t2_credit_vc", bus.credit_vc, 1);
    step();
    chk("t2_credit_t3", bus.credit_valid, 0);
    chk("t2_done", done, 0);
    chk("t2_err", err, 0);

    // 4-flit packet on vc0 then one-flit packet on vc1, back-to-back
    do_init(4'd3, 3'd2, 4'd3, 16'd2);
    pkt3[0] = mk(2'd0, 1'b1, 1'b0, 4'd3);
    pkt3[1] = mk(2'd0, 1'b0, 1'b0, 4'd3);
    pkt3[2] = mk(2'd0, 1'b0, 1'b0, 4'd3);
    pkt3[3] = mk(2'd0, 1'b0, 1'b1, 4'd3);
    pkt3[4] = mk(2'd1, 1'b1, 1'b1, 4'd3);
    for (int k = 0; k < 8; k++) begin
      bus.flit = (k < 5) ? pkt3[k] : '0;
      step();
      chk($sformatf("t3_busy_%0d", k), vc_busy, e_busy[k]);
      chk($sformatf("t3_fc_%0d", k), flit_count, e_fc[k]);
      chk($sformatf("t3_pc_%0d", k), pkt_count, e_pc[k]);
      chk($sformatf("t3_done_%0d", k), done, e_done[k]);
      chk($sformatf("t3_cv_%0d", k), bus.credit_valid, e_cv[k]);
      if (e_cv[k] != 0) chk($sformatf("t3_cvc_%0d", k), bus.credit_vc, e_cvc[k]);
    end
    chk("t3_err", err, 0);

    // flit accepted while DONE
    bus.flit = mk(2'd0, 1'b1, 1'b1, 4'd3);
    step();
    bus.flit = '0;
    chk("done_flit_fc", flit_count, 6);
    chk("done_flit_pc", pkt_count, 3);
    chk("done_flit_done", done, 1);
    chk("done_flit_err", err, CHK_EN ? 32'd1 : 32'd0);
    chk("done_flit_code", err_code, CHK_EN ? 32'd5 : 32'd0);

    // out-of-range vc dropped, credit delay 1
    do_init(4'd3, 3'd2, 4'd1, 16'd5);
    chk("t4_err_cleared", err, 0);
    chk("t4_done_cleared", done, 0);
    bus.flit = mk(2'd3, 1'b1, 1'b1, 4'd3);
    step();
    chk("t4_vc3_fc", flit_count, 0);
    chk("t4_vc3_pc", pkt_count, 0);
    chk("t4_vc3_credit", bus.credit_valid, 0);
    chk("t4_vc3_err", err, CHK_EN ? 32'd1 : 32'd0);
    chk("t4_vc3_code", err_code, CHK_EN ? 32'd4 : 32'd0);
    bus.flit = mk(2'd2, 1'b1, 1'b0, 4'd3);
    step();
    chk("t4_vc2_fc", flit_count, 0);
    chk("t4_vc2_busy", vc_busy, 0);
    chk("t4_vc2_credit", bus.credit_valid, 0);
    bus.flit = mk(2'd1, 1'b1, 1'b0, 4'd3);
    step();
    bus.flit = '0;
    chk("t4_vc1_fc", flit_count, 1);
    chk("t4_vc1_busy", vc_busy, 4'b0010);
    chk("t4_vc1_credit", bus.credit_valid, 1);
    chk("t4_vc1_credit_vc", bus.credit_vc, 1);
    chk("t4_vc1_code", err_code, CHK_EN ? 32'd4 : 32'd0);
    step();
    chk("t4_credit_end", bus.credit_valid, 0);

    // bad destination, then body on idle vc; credit delay 0 acts as 1
    do_init(4'd3, 3'd4, 4'd0, 16'd5);
    chk("t5_err_cleared", err, 0);
    chk("t5_busy_cleared", vc_busy, 0);
    bus.flit = mk(2'd2, 1'b1, 1'b1, 4'd5);
    step();
    chk("t5_dst_code", err_code, CHK_EN ? 32'd1 : 32'd0);
    chk("t5_dst_fc", flit_count, 1);
    chk("t5_dst_pc", pkt_count, 1);
    chk("t5_dst_credit", bus.credit_valid, 1);
    chk("t5_dst_credit_vc", bus.credit_vc, 2);
    bus.flit = mk(2'd0, 1'b0, 1'b0, 4'd3);
    step();
    bus.flit = '0;
    chk("t5_body_code", err_code, CHK_EN ? 32'd1 : 32'd0);
    chk("t5_body_fc", flit_count, 2);
    chk("t5_body_busy", vc_busy, 0);
    chk("t5_body_credit", bus.credit_valid, 1);
    chk("t5_body_credit_vc", bus.credit_vc, 0);

    // credit delay 12 clamps to 8
    do_init(4'd3, 3'd4, 4'd12, 16'd5);
    bus.flit = mk(2'd3, 1'b1, 1'b1, 4'd3);
    for (int k = 0; k < 9; k++) begin
      step();
      bus.flit = '0;
      chk($sformatf("clamp_cv_%0d", k), bus.credit_valid, (k == 7) ? 32'd1 : 32'd0);
      if (k == 7) chk("clamp_cvc", bus.credit_vc, 3);
    end

    // delay 8, three credits in flight, init flushes them
    do_init(4'd3, 3'd4, 4'd8, 16'd5);
    for (int k = 0; k < 3; k++) begin
      bus.flit = mk(VC_W'(k), 1'b1, 1'b1, 4'd3);
      step();
    end
    chk("t6_fc_before", flit_count, 3);
    bus.flit = mk(2'd3, 1'b1, 1'b1, 4'd3);
    init = 1'b1;
    step();
    init = 1'b0;
    bus.flit = '0;
    chk("t6_fc_after_init", flit_count, 0);
    chk("t6_pc_after_init", pkt_count, 0);
    chk("t6_done_after_init", done, 0);
    chk("t6_credit_after_init", bus.credit_valid, 0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("t6_flushed_cv_%0d", k), bus.credit_valid, 0);
    end
    bus.flit = mk(2'd1, 1'b1, 1'b1, 4'd3);
    step();
    bus.flit = '0;
    chk("t6_run_fc", flit_count, 1);
    chk("t6_run_pc", pkt_count, 1);
    chk("t6_run_done", done, 0);

    // expected = 0: done in the cycle after init
    do_init(4'd3, 3'd4, 4'd1, 16'd0);
    chk("exp0_done", done, 1);

    // reset mid-traffic
    do_init(4'd3, 3'd2, 4'd2, 16'd5);
    bus.flit = mk(2'd0, 1'b1, 1'b0, 4'd3);
    step();
    chk("t1_busy_before", vc_busy, 4'b0001);
    bus.flit = mk(2'd0, 1'b0, 1'b0, 4'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("t1_async_fc", flit_count, 0);
    chk("t1_async_busy", vc_busy, 0);
    chk("t1_async_credit", bus.credit_valid, 0);
    chk("t1_async_done", done, 0);
    step();
    rst = 1'b0;
    bus.flit = mk(2'd0, 1'b1, 1'b1, 4'd3);
    step();
    chk("t1_ignored_fc", flit_count, 0);
    chk("t1_ignored_credit0", bus.credit_valid, 0);
    step();
    bus.flit = '0;
    chk("t1_ignored_pc", pkt_count, 0);
    chk("t1_ignored_credit1", bus.credit_valid, 0);
    chk("t1_err", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
